// File: rtl/life_pkg.sv
// Shared types, constants and helpers for the Game-of-Life grid engine.
// Holds the FSM state encoding, neighbour-count width and the standard rule masks.
package life_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        EVOLVE = 2'd1,
        EMIT   = 2'd2
    } life_state_e;

    localparam int NBR_CNT_W = 4;

    localparam logic [8:0] CONWAY_B   = 9'h008;
    localparam logic [8:0] CONWAY_S   = 9'h00C;
    localparam logic [8:0] HIGHLIFE_B = 9'h048;

    // Eight neighbours can never exceed 8, so four bits hold the sum without overflow.
    function automatic logic [NBR_CNT_W-1:0] popcount8(input logic [7:0] bits);
        logic [NBR_CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + NBR_CNT_W'(bits[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// Combinational next-row evaluator: applies the birth/survival masks to every
// column of a row in parallel, given the rows above and below.
module life_row_rule
    import life_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] up,
    input  logic [WIDTH-1:0] centre,
    input  logic [WIDTH-1:0] down,
    input  logic             wrap,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    output logic [WIDTH-1:0] next_row
);

    // Bit c of a *_left_s vector holds column c-1; bit c of *_right_s holds column c+1.
    logic [WIDTH-1:0] up_left_s, up_right_s;
    logic [WIDTH-1:0] mid_left_s, mid_right_s;
    logic [WIDTH-1:0] down_left_s, down_right_s;

    // Horizontal neighbour alignment with optional wrap of the edge columns.
    always_comb begin
        up_left_s    = {up[WIDTH-2:0], up[WIDTH-1] & wrap};
        up_right_s   = {up[0] & wrap, up[WIDTH-1:1]};
        mid_left_s   = {centre[WIDTH-2:0], centre[WIDTH-1] & wrap};
        mid_right_s  = {centre[0] & wrap, centre[WIDTH-1:1]};
        down_left_s  = {down[WIDTH-2:0], down[WIDTH-1] & wrap};
        down_right_s = {down[0] & wrap, down[WIDTH-1:1]};
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        logic [NBR_CNT_W-1:0] cnt_s;
        assign cnt_s = popcount8({up_left_s[c], up[c], up_right_s[c],
                                  mid_left_s[c], mid_right_s[c],
                                  down_left_s[c], down[c], down_right_s[c]});
        assign next_row[c] = centre[c] ? survive_mask[cnt_s] : birth_mask[cnt_s];
    end

endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life grid processor: loads a frame row by row, evolves it in place for a
// programmable number of generations, then streams it out with valid/ready.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int GEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    input  logic             wrap_en,
    input  logic [GEN_W-1:0] generations,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_row,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_row,
    output logic             m_last
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    life_state_e      state_r, state_next_s;
    logic [ROW_W-1:0] row_idx_r, row_nxt_s;
    logic [GEN_W-1:0] gen_cnt_r, gen_inc_s, gens_r;
    logic [8:0]       birth_r, survive_r;
    logic             wrap_r;
    logic [WIDTH-1:0] grid_r [HEIGHT];
    logic [WIDTH-1:0] prev_old_r, row0_old_r;
    logic [WIDTH-1:0] up_s, centre_s, down_s, new_row_s;

    logic             s_ready_r, m_valid_r, m_last_r;
    logic [WIDTH-1:0] m_row_r;
    logic             s_ready_next_s, m_valid_next_s, m_last_next_s;
    logic [WIDTH-1:0] m_row_next_s;

    logic s_fire_s, m_fire_s, last_row_s, gen_done_s;

    // Handshake and counter decode shared by all processes.
    always_comb begin
        s_fire_s   = s_valid && s_ready_r;
        m_fire_s   = m_valid_r && m_ready;
        last_row_s = (row_idx_r == LAST_ROW);
        row_nxt_s  = last_row_s ? '0 : row_idx_r + ROW_W'(1);
        gen_inc_s  = gen_cnt_r + GEN_W'(1);
        gen_done_s = (gen_inc_s == gens_r);
    end

    // Vertical neighbours; prev_old/row0_old hold pre-update rows already overwritten in place.
    always_comb begin
        centre_s = grid_r[row_idx_r];
        if (row_idx_r == '0) begin
            up_s = wrap_r ? grid_r[HEIGHT-1] : '0;
        end else begin
            up_s = prev_old_r;
        end
        if (last_row_s) begin
            down_s = wrap_r ? row0_old_r : '0;
        end else begin
            down_s = grid_r[row_nxt_s];
        end
    end

    life_row_rule #(
        .WIDTH(WIDTH)
    ) u_row_rule (
        .up          (up_s),
        .centre      (centre_s),
        .down        (down_s),
        .wrap        (wrap_r),
        .birth_mask  (birth_r),
        .survive_mask(survive_r),
        .next_row    (new_row_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (s_fire_s && last_row_s) begin
                    state_next_s = (gens_r != '0) ? EVOLVE : EMIT;
                end else begin
                    state_next_s = LOAD;
                end
            end
            EVOLVE: begin
                if (last_row_s && gen_done_s) begin
                    state_next_s = EMIT;
                end else begin
                    state_next_s = EVOLVE;
                end
            end
            EMIT: begin
                if (m_fire_s && last_row_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = EMIT;
                end
            end
            default: state_next_s = LOAD;
        endcase
    end

    // Output decode: next values for the registered stream outputs.
    always_comb begin
        s_ready_next_s = (state_next_s == LOAD);
        m_valid_next_s = (state_next_s == EMIT);
        m_row_next_s   = m_row_r;
        m_last_next_s  = m_last_r;
        if (state_next_s != EMIT) begin
            m_row_next_s  = '0;
            m_last_next_s = 1'b0;
        end else if (state_r != EMIT) begin
            // Row 0 is final by now: written at load or in the first cycle of the last generation.
            m_row_next_s  = grid_r[0];
            m_last_next_s = 1'b0;
        end else if (m_fire_s) begin
            m_row_next_s  = grid_r[row_nxt_s];
            m_last_next_s = (row_nxt_s == LAST_ROW);
        end else begin
            m_row_next_s  = m_row_r;
            m_last_next_s = m_last_r;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            m_row_r   <= '0;
            m_last_r  <= 1'b0;
        end else begin
            s_ready_r <= s_ready_next_s;
            m_valid_r <= m_valid_next_s;
            m_row_r   <= m_row_next_s;
            m_last_r  <= m_last_next_s;
        end
    end

    // Grid storage, frame configuration and row/generation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx_r  <= '0;
            gen_cnt_r  <= '0;
            gens_r     <= '0;
            birth_r    <= '0;
            survive_r  <= '0;
            wrap_r     <= 1'b0;
            prev_old_r <= '0;
            row0_old_r <= '0;
            for (int r = 0; r < HEIGHT; r++) begin
                grid_r[r] <= '0;
            end
        end else begin
            case (state_r)
                LOAD: begin
                    if (s_fire_s) begin
                        grid_r[row_idx_r] <= s_row;
                        row_idx_r         <= row_nxt_s;
                        if (row_idx_r == '0) begin
                            birth_r   <= birth_mask;
                            survive_r <= survive_mask;
                            wrap_r    <= wrap_en;
                            gens_r    <= generations;
                        end
                    end
                end
                EVOLVE: begin
                    grid_r[row_idx_r] <= new_row_s;
                    prev_old_r        <= centre_s;
                    if (row_idx_r == '0) begin
                        row0_old_r <= centre_s;
                    end
                    row_idx_r <= row_nxt_s;
                    if (last_row_s) begin
                        gen_cnt_r <= gen_inc_s;
                    end
                end
                EMIT: begin
                    if (m_fire_s) begin
                        row_idx_r <= row_nxt_s;
                        if (last_row_s) begin
                            gen_cnt_r <= '0;
                        end
                    end
                end
                default: begin
                    row_idx_r <= '0;
                    gen_cnt_r <= '0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_row   = m_row_r;
    assign m_last  = m_last_r;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: a 5x5 and an 8x8 instance share the input
// stimulus, with hand-computed expected frames for each pattern.
module tb_life_grid_engine;
    import life_pkg::*;

    logic       clk;
    logic       rst;
    logic [8:0] birth_mask, survive_mask;
    logic       wrap_en;
    logic [7:0] generations;
    logic       s_valid;
    logic [7:0] s_row;
    logic       m_ready;
    int         cur_sel;

    logic       s_valid5, s_ready5, m_valid5, m_last5;
    logic [4:0] m_row5;
    logic       s_valid8, s_ready8, m_valid8, m_last8;
    logic [7:0] m_row8;

    int n_checks;
    int n_errors;
    logic [7:0] got_rows [8];

    assign s_valid5 = s_valid & (cur_sel == 0);
    assign s_valid8 = s_valid & (cur_sel == 1);

    life_grid_engine #(.WIDTH(5), .HEIGHT(5), .GEN_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
        .wrap_en(wrap_en), .generations(generations), .s_valid(s_valid5),
        .s_ready(s_ready5), .s_row(s_row[4:0]), .m_valid(m_valid5), .m_ready(m_ready),
        .m_row(m_row5), .m_last(m_last5)
    );

    life_grid_engine #(.WIDTH(8), .HEIGHT(8), .GEN_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
        .wrap_en(wrap_en), .generations(generations), .s_valid(s_valid8),
        .s_ready(s_ready8), .s_row(s_row), .m_valid(m_valid8), .m_ready(m_ready),
        .m_row(m_row8), .m_last(m_last8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sr(input int sel);
        return (sel == 0) ? s_ready5 : s_ready8;
    endfunction

    function automatic logic mv(input int sel);
        return (sel == 0) ? m_valid5 : m_valid8;
    endfunction

    function automatic logic [7:0] mrow(input int sel);
        return (sel == 0) ? {3'b000, m_row5} : m_row8;
    endfunction

    function automatic logic ml(input int sel);
        return (sel == 0) ? m_last5 : m_last8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Config ports are scrambled after the first row to show the held copies are used.
    task automatic load_frame(input int sel, input logic [7:0] rows [8], input logic [8:0] b,
                              input logic [8:0] sv, input logic w, input logic [7:0] g);
        int h;
        int c;
        h = (sel == 0) ? 5 : 8;
        cur_sel = sel;
        birth_mask = b; survive_mask = sv; wrap_en = w; generations = g;
        for (int r = 0; r < h; r++) begin
            s_row = rows[r];
            s_valid = 1'b1;
            c = 0;
            while (!sr(sel) && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("load_ready", 32'(sr(sel)), 32'd1);
            @(negedge clk);
            if (r == 0) begin
                birth_mask = ~b; survive_mask = ~sv; wrap_en = ~w; generations = g + 8'd5;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic collect(input int sel, input bit toggle, input int exp_lat);
        int h, lat, k, cyc;
        bit ph, pstall;
        logic [7:0] prow;
        logic plast;
        h = (sel == 0) ? 5 : 8;
        m_ready = 1'b0;
        lat = 1;
        while (!mv(sel) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        k = 0; cyc = 0; ph = 1'b1; pstall = 1'b0; prow = '0; plast = 1'b0;
        while (k < h && cyc < 2000) begin
            if (mv(sel)) begin
                if (pstall) begin
                    check("stall_row", 32'(mrow(sel)), 32'(prow));
                    check("stall_last", 32'(ml(sel)), 32'(plast));
                end
                check("s_ready_in_emit", 32'(sr(sel)), 32'd0);
                m_ready = toggle ? ph : 1'b1;
                ph = ~ph;
                prow = mrow(sel);
                plast = ml(sel);
                pstall = ~m_ready;
                if (m_ready) begin
                    got_rows[k] = mrow(sel);
                    check($sformatf("m_last_r%0d", k), 32'(ml(sel)), 32'(k == h - 1));
                    k++;
                end
            end else begin
                m_ready = 1'b0;
                pstall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check("frame_rows", k, h);
        check("post_s_ready", 32'(sr(sel)), 32'd1);
        check("post_m_valid", 32'(mv(sel)), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int h, input logic [7:0] exp [8]);
        for (int r = 0; r < h; r++) begin
            check($sformatf("%s_r%0d", tag, r), 32'(got_rows[r]), 32'(exp[r]));
        end
    endtask

    initial begin
        logic [7:0] f_in [8];
        logic [7:0] f_exp [8];
        logic [7:0] glider [8];
        bit differs;

        n_checks = 0; n_errors = 0;
        rst = 1'b1; s_valid = 1'b0; s_row = '0; m_ready = 1'b0; cur_sel = 0;
        birth_mask = '0; survive_mask = '0; wrap_en = 1'b0; generations = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready5", 32'(s_ready5), 32'd1);
        check("rst_m_valid5", 32'(m_valid5), 32'd0);
        check("rst_m_row8", 32'(m_row8), 32'd0);
        check("rst_m_last8", 32'(m_last8), 32'd0);
        check("rst_s_ready8", 32'(s_ready8), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Blinker on 5x5: horizontal -> vertical after one generation, back after two.
        f_in  = '{8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_exp = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        load_frame(0, f_in, CONWAY_B, CONWAY_S, 1'b0, 8'd1);
        collect(0, 1'b0, 6);
        check_frame("blinker_g1", 5, f_exp);
        load_frame(0, f_in, CONWAY_B, CONWAY_S, 1'b0, 8'd2);
        collect(0, 1'b0, 11);
        check_frame("blinker_g2", 5, f_in);

        // Glider on 8x8 torus: 32 generations translate it by 8 cells = identity.
        glider = '{8'h00, 8'h04, 8'h08, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
        load_frame(1, glider, CONWAY_B, CONWAY_S, 1'b1, 8'd32);
        collect(1, 1'b0, 257);
        check_frame("glider_wrap", 8, glider);
        load_frame(1, glider, CONWAY_B, CONWAY_S, 1'b0, 8'd32);
        collect(1, 1'b0, 257);
        differs = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (got_rows[r] !== glider[r]) differs = 1'b1;
        end
        check("glider_nowrap_differs", 32'(differs), 32'd1);

        // Block split across the four corners.
        f_in  = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
        f_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_frame(1, f_in, CONWAY_B, CONWAY_S, 1'b1, 8'd1);
        collect(1, 1'b0, 9);
        check_frame("corner_wrap", 8, f_in);
        load_frame(1, f_in, CONWAY_B, CONWAY_S, 1'b0, 8'd1);
        collect(1, 1'b0, 9);
        check_frame("corner_nowrap", 8, f_exp);

        // Pass-through with gens=0 and a 1010 ready pattern.
        f_in = '{8'h3C, 8'h81, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h18, 8'hE7};
        load_frame(1, f_in, CONWAY_B, CONWAY_S, 1'b0, 8'd0);
        collect(1, 1'b1, 1);
        check_frame("stream", 8, f_in);

        // Abort a 3-generation frame with reset in its third EVOLVE cycle.
        load_frame(1, glider, CONWAY_B, CONWAY_S, 1'b1, 8'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_s_ready", 32'(s_ready8), 32'd1);
        check("abort_m_valid", 32'(m_valid8), 32'd0);

        // HighLife: dead centre with 6 neighbours is born; Conway leaves it dead.
        f_in  = '{8'h00, 8'h00, 8'h00, 8'h38, 8'h00, 8'h38, 8'h00, 8'h00};
        f_exp = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        load_frame(1, f_in, HIGHLIFE_B, CONWAY_S, 1'b0, 8'd1);
        collect(1, 1'b0, 9);
        check_frame("highlife", 8, f_exp);
        f_exp = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h00};
        load_frame(1, f_in, CONWAY_B, CONWAY_S, 1'b0, 8'd1);
        collect(1, 1'b0, 9);
        check_frame("conway6", 8, f_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
